// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
//   Two-entry registered valid/ready stage placed in front of each datapath
//   register bank. A main slot drives out_data directly and a skid slot
//   catches the one payload still in flight when the downstream stalls.
//   Outputs come straight from flops, so out_ready never reaches in_ready
//   combinationally, and a payload can move through every cycle.
//
//   Optional build macro: PIPE_SKID_PERF_EN
//     Adds perf_stall_count, a saturating count of cycles where out_valid
//     is high and out_ready is low. Without the macro, the port and the
//     counter are not built. The handshake behaves the same in both builds.
module pipe_skid_buffer #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [31:0]      perf_stall_count
`endif
);

    // Bit 0 is the main-slot valid flag and bit 1 is the skid-slot valid
    // flag. This lets out_valid and in_ready come directly from state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_p0;
    state_t           state_nxt;

    logic             in_fire;
    logic             out_fire;

    logic             main_ld_in;
    logic             main_ld_skid;
    logic             skid_ld;

    logic [width-1:0] main_data_p0;
    logic [width-1:0] skid_data_p0;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register: the reset is asynchronous and empties the buffer at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p0 <= EMPTY;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Next-state decode: flush wins over both handshakes.
    always_comb begin
        state_nxt = state_p0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (in_fire) state_nxt = BUSY;
                end
                BUSY: begin
                    if (in_fire && !out_fire)      state_nxt = FULL;
                    else if (!in_fire && out_fire) state_nxt = EMPTY;
                end
                FULL: begin
                    if (out_fire) state_nxt = BUSY;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Output decode: both handshake outputs are single state flops.
    always_comb begin
        out_valid = state_p0[0];
        in_ready  = !state_p0[1];
    end

    // Slot-load strobes: a flush cycle loads nothing, so accepted and
    // presented payloads in that cycle are both dropped.
    always_comb begin
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (!flush) begin
            case (state_p0)
                EMPTY: begin
                    main_ld_in = in_fire;
                end
                BUSY: begin
                    main_ld_in = in_fire && out_fire;
                    skid_ld    = in_fire && !out_fire;
                end
                FULL: begin
                    main_ld_skid = out_fire;
                end
                default: begin
                    main_ld_in   = 1'b0;
                    main_ld_skid = 1'b0;
                    skid_ld      = 1'b0;
                end
            endcase
        end
    end

    // Main slot: cleared on reset so out_data reads zero until the first payload arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data_p0 <= '0;
        end else if (main_ld_in) begin
            main_data_p0 <= in_data;
        end else if (main_ld_skid) begin
            main_data_p0 <= skid_data_p0;
        end
    end

    // Skid slot: its contents matter only while the FULL flag is set, so it has no reset.
    always_ff @(posedge clk) begin
        if (skid_ld) begin
            skid_data_p0 <= in_data;
        end
    end

    assign out_data = main_data_p0;

`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_cnt_p0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Stall counter: counts stalled cycles, stops at all-ones, and only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_p0 <= 32'd0;
        end else if (out_valid && !out_ready) begin
            stall_cnt_p0 <= sat_inc(stall_cnt_p0);
        end
    end

    assign perf_stall_count = stall_cnt_p0;
`endif

    // A stalled payload must stay on out_data until the downstream takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule
